// File: rtl/spk_write_packer.sv
// rtl/spk_write_packer.sv - packs 2-bit spike codes into 16-bit spike SRAM words
// Optional sticky address-wrap flag and write suppression: SPK_PACK_OVF_EN.
module spk_write_packer #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  input  logic [1:0]        in_spk,
  output logic              in_ready,
  input  logic              flush,
  output logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_we,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
`ifdef SPK_PACK_OVF_EN
  ,
  output logic              ovf
`endif
);

  logic [2:0]        slot_q, slot_d;
  logic [15:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_we_q, wr_we_d;
  logic              done_q, done_d;
  logic              wr_allow;
  logic              accept;
  logic              do_write;
  logic [15:0]       fill;
  logic [15:0]       wdata;

`ifdef SPK_PACK_OVF_EN
  logic ovf_q, ovf_d;
  assign wr_allow = !ovf_q;
  assign ovf      = ovf_q;
`else
  assign wr_allow = 1'b1;
`endif

  assign in_ready   = !start && !flush;
  assign accept     = in_valid && in_ready;
  assign wr_data    = wr_data_q;
  assign wr_addr    = wr_addr_q;
  assign wr_we      = wr_we_q;
  assign done       = done_q;
  assign word_count = cnt_q;

  always_comb begin
    slot_d    = slot_q;
    pack_d    = pack_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_we_d   = 1'b0;
    done_d    = 1'b0;
    do_write  = 1'b0;
`ifdef SPK_PACK_OVF_EN
    ovf_d     = ovf_q;
`endif
    // Word as it would look with the incoming code placed in the current slot
    fill = pack_q;
    fill[{slot_q, 1'b0} +: 2] = in_spk;
    wdata = fill;

    if (start) begin
      slot_d = 3'd0;
      pack_d = 16'd0;
      addr_d = start_addr;
      cnt_d  = '0;
`ifdef SPK_PACK_OVF_EN
      ovf_d  = 1'b0;
`endif
    end else if (flush) begin
      done_d = 1'b1;
      if (slot_q != 3'd0) begin
        do_write = 1'b1;
        wdata    = pack_q;
      end
    end else if (accept) begin
      if (slot_q == 3'd7) begin
        do_write = 1'b1;
      end else begin
        pack_d = fill;
        slot_d = slot_q + 3'd1;
      end
    end

    // Address and count advance even when an overflowed write is suppressed
    if (do_write) begin
      slot_d = 3'd0;
      pack_d = 16'd0;
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (wr_allow) begin
        wr_we_d   = 1'b1;
        wr_data_d = wdata;
        wr_addr_d = addr_q;
`ifdef SPK_PACK_OVF_EN
        if (addr_q == {ADDR_W{1'b1}}) ovf_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= 3'd0;
      pack_q    <= 16'd0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_data_q <= 16'd0;
      wr_addr_q <= '0;
      wr_we_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPK_PACK_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      slot_q    <= slot_d;
      pack_q    <= pack_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_we_q   <= wr_we_d;
      done_q    <= done_d;
`ifdef SPK_PACK_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_spk_write_packer.sv
// tb/tb_spk_write_packer.sv - scoreboard bench for spk_write_packer
// Expects SPK_PACK_OVF_EN to match the RTL build.
module tb_spk_write_packer;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              in_valid = 1'b0;
  logic [1:0]        in_spk = 2'd0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_we;
  logic              done;
  logic [ADDR_W-1:0] word_count;
`ifdef SPK_PACK_OVF_EN
  logic              ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [24:0] exp_wr_q[$];
  int          exp_done_n = 0;

  spk_write_packer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_spk(in_spk), .in_ready(in_ready), .flush(flush),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_we(wr_we), .done(done),
    .word_count(word_count)
`ifdef SPK_PACK_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every DUT write and done pulse against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_we) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", {7'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          logic [24:0] e;
          e = exp_wr_q.pop_front();
          check("write_addr", {23'd0, wr_addr}, {23'd0, e[24:16]});
          check("write_data", {16'd0, wr_data}, {16'd0, e[15:0]});
        end
      end
      if (done) begin
        check("done_expected", (exp_done_n > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_done_n > 0) exp_done_n--;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [1:0] c);
    in_valid = 1'b1;
    in_spk   = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    start = 1'b1;
    start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  initial begin
    logic [1:0] seq [8];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

    #12;
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_wr_addr", {23'd0, wr_addr}, 32'd0);
    check("rst_wr_we", {31'd0, wr_we}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_word_count", {23'd0, word_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // First word: codes 0,1,2,3,3,2,1,0 -> 0x1BE4 at 0x010
    start = 1'b1; start_addr = 9'h010; #1;
    check("ready_during_start", {31'd0, in_ready}, 32'd0);
    tick(); start = 1'b0;
    push_wr(9'h010, 16'h1BE4);
    for (int i = 0; i < 8; i++) feed(seq[i]);
    check("first_we", {31'd0, wr_we}, 32'd1);
    check("first_word_count", {23'd0, word_count}, 32'd1);

    // 20 codes of 01, then flush the 4-code partial word
    push_wr(9'h011, 16'h5555);
    push_wr(9'h012, 16'h5555);
    push_wr(9'h013, 16'h0055);
    for (int i = 0; i < 20; i++) feed(2'd1);
    exp_done_n++;
    flush = 1'b1; #1;
    check("ready_during_flush", {31'd0, in_ready}, 32'd0);
    tick(); flush = 1'b0;
    check("partial_flush_done", {31'd0, done}, 32'd1);
    check("partial_flush_we", {31'd0, wr_we}, 32'd1);
    check("partial_word_count", {23'd0, word_count}, 32'd4);

    // Empty flush with in_valid held high: done only, no code taken
    exp_done_n++;
    flush = 1'b1; in_valid = 1'b1; in_spk = 2'd1; #1;
    check("ready_empty_flush", {31'd0, in_ready}, 32'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    check("empty_flush_done", {31'd0, done}, 32'd1);
    check("empty_flush_we", {31'd0, wr_we}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    exp_done_n++;
    flush = 1'b1; tick(); flush = 1'b0;

    // Three pending codes discarded by a start with in_valid held high
    for (int i = 0; i < 3; i++) feed(2'd3);
    in_valid = 1'b1; in_spk = 2'd2;
    do_start(9'h020);
    in_valid = 1'b0;
    check("start_word_count", {23'd0, word_count}, 32'd0);
    check("start_no_write", {31'd0, wr_we}, 32'd0);
    push_wr(9'h020, 16'hAAAA);
    for (int i = 0; i < 8; i++) feed(2'd2);
    exp_done_n++;
    flush = 1'b1; tick(); flush = 1'b0;

    // Address wrap from 0x1FF
    do_start(9'h1FF);
    push_wr(9'h1FF, 16'hE4E4);
`ifndef SPK_PACK_OVF_EN
    push_wr(9'h000, 16'hE4E4);
`endif
    for (int i = 0; i < 16; i++) feed(2'(i % 4));
    check("wrap_word_count", {23'd0, word_count}, 32'd2);
`ifdef SPK_PACK_OVF_EN
    check("wrap_ovf", {31'd0, ovf}, 32'd1);
`endif
    tick();

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) feed(2'd1);
    #2 rst_n = 1'b0; #1;
    check("async_wr_data", {16'd0, wr_data}, 32'd0);
    check("async_wr_addr", {23'd0, wr_addr}, 32'd0);
    check("async_word_count", {23'd0, word_count}, 32'd0);
`ifdef SPK_PACK_OVF_EN
    check("async_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    tick();
    push_wr(9'h000, 16'hFFFF);
    for (int i = 0; i < 8; i++) feed(2'd3);
    check("post_reset_word_count", {23'd0, word_count}, 32'd1);

    repeat (4) tick();
    check("pending_writes", exp_wr_q.size(), 32'd0);
    check("pending_done", exp_done_n, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
